// File: rtl/lieat_exu_mulctl_pkg.sv
// Shared op encodings, FSM state/bit-index constants and signedness decode
// for the multiply control block.
package lieat_exu_mulctl_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    localparam int ST_IDLE_BIT  = 0;
    localparam int ST_ISSUE_BIT = 1;
    localparam int ST_WAIT_BIT  = 2;
    localparam int ST_RESP_BIT  = 3;
    localparam int ST_DRAIN_BIT = 4;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ISSUE = 5'b00010,
        ST_WAIT  = 5'b00100,
        ST_RESP  = 5'b01000,
        ST_DRAIN = 5'b10000
    } state_e;

    // Returns {signed1, signed2} for an op.
    function automatic logic [1:0] op_sign(input logic [1:0] op);
        logic [1:0] sgn;
        case (op)
            OP_MUL, OP_MULH: sgn = 2'b11;
            OP_MULHSU:       sgn = 2'b10;
            OP_MULHU:        sgn = 2'b00;
            default:         sgn = 2'b00;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/lieat_general_rrarb2.sv
// Two-requester round-robin arbiter with one-hot grant; the pointer moves to
// the other port after every grant.
module lieat_general_rrarb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic       ptr_r;
    logic [1:0] pick_s;

    // Pick a requester; on contention the pointer's port wins
    always_comb begin
        pick_s = 2'b00;
        case (req)
            2'b01:   pick_s = 2'b01;
            2'b10:   pick_s = 2'b10;
            2'b11:   pick_s = ptr_r ? 2'b10 : 2'b01;
            default: pick_s = 2'b00;
        endcase
        if (en) begin
            grant = pick_s;
        end else begin
            grant = 2'b00;
        end
    end

    // Pointer register: points away from the port just granted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_r <= 1'b0;
        end else if (grant != 2'b00) begin
            ptr_r <= grant[0];
        end
    end

endmodule

// File: rtl/lieat_exu_mulctl.sv
// Multiply control: arbitrates two requesters onto one multiplier and returns
// the selected product half. Define LIEAT_MULCTL_FUSE_EN for last-result reuse.
module lieat_exu_mulctl
    import lieat_exu_mulctl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_op,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic [TAGW-1:0] req0_tag,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_op,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    input  logic [TAGW-1:0] req1_tag,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_port,
    output logic [TAGW-1:0] rsp_tag,
    output logic [XLEN-1:0] rsp_data,
    output logic            mul_i_valid,
    input  logic            mul_i_ready,
    output logic            mul_i_signed1,
    output logic            mul_i_signed2,
    output logic [XLEN-1:0] mul_i_multiplicand,
    output logic [XLEN-1:0] mul_i_multiplier,
    input  logic            mul_o_valid,
    output logic            mul_o_ready,
    input  logic [XLEN-1:0] mul_o_resh,
    input  logic [XLEN-1:0] mul_o_resl
);

    state_e          state_r;
    state_e          state_nx_s;
    logic            alive_r;
    logic            arb_en_s;
    logic [1:0]      grant_s;
    logic            accept_s;
    logic            capture_s;
    logic            sel_port_s;
    logic [1:0]      sel_op_s;
    logic [1:0]      sel_sgn_s;
    logic [XLEN-1:0] sel_rs1_s;
    logic [XLEN-1:0] sel_rs2_s;
    logic [TAGW-1:0] sel_tag_s;
    logic            hit_s;
    logic [XLEN-1:0] fuse_data_s;
    logic            port_r;
    logic [TAGW-1:0] tag_r;
    logic [1:0]      op_r;
    logic [1:0]      sgn_r;
    logic [XLEN-1:0] rs1_r;
    logic [XLEN-1:0] rs2_r;
    logic [XLEN-1:0] data_r;

    // alive_r keeps both ready outputs low while reset is held
    assign arb_en_s  = alive_r & state_r[ST_IDLE_BIT] & ~flush;
    assign accept_s  = |grant_s;
    assign capture_s = state_r[ST_WAIT_BIT] & ~flush & mul_o_valid;
    assign sel_sgn_s = op_sign(sel_op_s);

    lieat_general_rrarb2 u_arb (
        .clock (clock),
        .reset (reset),
        .req   ({req1_valid, req0_valid}),
        .en    (arb_en_s),
        .grant (grant_s)
    );

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];

    // Out-of-reset flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alive_r <= 1'b0;
        end else begin
            alive_r <= 1'b1;
        end
    end

    // Payload mux of the granted requester
    always_comb begin
        if (grant_s[1]) begin
            sel_port_s = 1'b1;
            sel_op_s   = req1_op;
            sel_rs1_s  = req1_rs1;
            sel_rs2_s  = req1_rs2;
            sel_tag_s  = req1_tag;
        end else begin
            sel_port_s = 1'b0;
            sel_op_s   = req0_op;
            sel_rs1_s  = req0_rs1;
            sel_rs2_s  = req0_rs2;
            sel_tag_s  = req0_tag;
        end
    end

`ifdef LIEAT_MULCTL_FUSE_EN
    logic              fuse_vld_r;
    logic [XLEN-1:0]   fuse_rs1_r;
    logic [XLEN-1:0]   fuse_rs2_r;
    logic [1:0]        fuse_sgn_r;
    logic [2*XLEN-1:0] fuse_prod_r;

    // Last-result entry, refreshed on every multiplier capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fuse_vld_r  <= 1'b0;
            fuse_rs1_r  <= {XLEN{1'b0}};
            fuse_rs2_r  <= {XLEN{1'b0}};
            fuse_sgn_r  <= 2'b00;
            fuse_prod_r <= {(2*XLEN){1'b0}};
        end else if (flush) begin
            fuse_vld_r <= 1'b0;
        end else if (capture_s) begin
            fuse_vld_r  <= 1'b1;
            fuse_rs1_r  <= rs1_r;
            fuse_rs2_r  <= rs2_r;
            fuse_sgn_r  <= sgn_r;
            fuse_prod_r <= {mul_o_resh, mul_o_resl};
        end
    end

    // MUL only needs the low half, which is independent of signedness
    always_comb begin
        if (fuse_vld_r && (sel_rs1_s == fuse_rs1_r) && (sel_rs2_s == fuse_rs2_r) &&
            ((sel_op_s == OP_MUL) || (sel_sgn_s == fuse_sgn_r))) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if (sel_op_s == OP_MUL) begin
            fuse_data_s = fuse_prod_r[XLEN-1:0];
        end else begin
            fuse_data_s = fuse_prod_r[2*XLEN-1:XLEN];
        end
    end
`else
    assign hit_s       = 1'b0;
    assign fuse_data_s = {XLEN{1'b0}};
`endif

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; flush wins over every same-cycle handshake
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = hit_s ? ST_RESP : ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    state_nx_s = ST_IDLE;
                end else if (mul_i_ready) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_nx_s = ST_DRAIN;
                end else if (mul_o_valid) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (flush || rsp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (mul_o_valid) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Request payload and response data registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            port_r <= 1'b0;
            tag_r  <= {TAGW{1'b0}};
            op_r   <= 2'b00;
            sgn_r  <= 2'b00;
            rs1_r  <= {XLEN{1'b0}};
            rs2_r  <= {XLEN{1'b0}};
            data_r <= {XLEN{1'b0}};
        end else if (accept_s) begin
            port_r <= sel_port_s;
            tag_r  <= sel_tag_s;
            op_r   <= sel_op_s;
            sgn_r  <= sel_sgn_s;
            rs1_r  <= sel_rs1_s;
            rs2_r  <= sel_rs2_s;
            if (hit_s) begin
                data_r <= fuse_data_s;
            end
        end else if (capture_s) begin
            data_r <= (op_r == OP_MUL) ? mul_o_resl : mul_o_resh;
        end
    end

    assign rsp_valid          = state_r[ST_RESP_BIT];
    assign rsp_port           = port_r;
    assign rsp_tag            = tag_r;
    assign rsp_data           = data_r;
    assign mul_i_valid        = state_r[ST_ISSUE_BIT];
    assign mul_i_signed1      = sgn_r[1];
    assign mul_i_signed2      = sgn_r[0];
    assign mul_i_multiplicand = rs1_r;
    assign mul_i_multiplier   = rs2_r;
    assign mul_o_ready        = state_r[ST_WAIT_BIT] | state_r[ST_DRAIN_BIT];

endmodule

// File: tb/tb_lieat_exu_mulctl.sv
// Directed bench for lieat_exu_mulctl with a behavioural multiplier model.
// Expectations follow LIEAT_MULCTL_FUSE_EN when it is defined.
module tb_lieat_exu_mulctl;

    localparam logic [1:0] T_MUL    = 2'b00;
    localparam logic [1:0] T_MULH   = 2'b01;
    localparam logic [1:0] T_MULHSU = 2'b10;
    localparam logic [1:0] T_MULHU  = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
    logic [31:0] req0_rs1 = 32'd0, req0_rs2 = 32'd0, req1_rs1 = 32'd0, req1_rs2 = 32'd0;
    logic [4:0]  req0_tag = 5'd0, req1_tag = 5'd0;
    logic        flush = 1'b0;
    logic        rsp_valid, rsp_port;
    logic        rsp_ready = 1'b1;
    logic [4:0]  rsp_tag;
    logic [31:0] rsp_data;
    logic        mul_i_valid, mul_i_ready, mul_i_signed1, mul_i_signed2;
    logic [31:0] mul_i_multiplicand, mul_i_multiplier;
    logic        mul_o_valid = 1'b0;
    logic        mul_o_ready;
    logic [31:0] mul_o_resh, mul_o_resl;

    logic        mbusy = 1'b0;
    int          mlat = 0;
    logic [63:0] mprod = 64'd0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int gcyc = 0;
    int issue_cnt = 0;
    int ores_cnt = 0;

    lieat_exu_mulctl #(.XLEN(32), .TAGW(5)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_tag(req1_tag),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .mul_i_valid(mul_i_valid), .mul_i_ready(mul_i_ready),
        .mul_i_signed1(mul_i_signed1), .mul_i_signed2(mul_i_signed2),
        .mul_i_multiplicand(mul_i_multiplicand), .mul_i_multiplier(mul_i_multiplier),
        .mul_o_valid(mul_o_valid), .mul_o_ready(mul_o_ready),
        .mul_o_resh(mul_o_resh), .mul_o_resl(mul_o_resl)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] mul_model(input logic s1, input logic s2,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = s1 ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s2 ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // Multiplier model: accepts when idle, answers after a few cycles
    assign mul_i_ready = ~mbusy;
    assign mul_o_resh  = mprod[63:32];
    assign mul_o_resl  = mprod[31:0];
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mbusy       <= 1'b0;
            mul_o_valid <= 1'b0;
            mlat        <= 0;
            mprod       <= 64'd0;
        end else if (mul_i_valid && mul_i_ready) begin
            mbusy <= 1'b1;
            mlat  <= 2;
            mprod <= mul_model(mul_i_signed1, mul_i_signed2, mul_i_multiplicand, mul_i_multiplier);
        end else if (mul_o_valid && mul_o_ready) begin
            mbusy       <= 1'b0;
            mul_o_valid <= 1'b0;
        end else if (mbusy && !mul_o_valid) begin
            if (mlat == 0) mul_o_valid <= 1'b1;
            else mlat <= mlat - 1;
        end
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mul_i_valid && mul_i_ready) issue_cnt <= issue_cnt + 1;
        if (mul_o_valid && mul_o_ready) ores_cnt <= ores_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic drive(input int p, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
        if (p == 0) begin
            req0_valid = v; req0_op = op; req0_rs1 = a; req0_rs2 = b; req0_tag = tg;
        end else begin
            req1_valid = v; req1_op = op; req1_rs1 = a; req1_rs2 = b; req1_tag = tg;
        end
    endtask

    // Present a request and return just after the accepting edge
    task automatic send(input int p, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg);
        int n;
        @(negedge clock);
        drive(p, 1'b1, op, a, b, tg);
        #1;
        n = 0;
        while (!rdy(p) && n < 50) begin
            @(negedge clock); #1; n++;
        end
        chk("grant", rdy(p), 1'b1);
        @(posedge clock); #1;
        gcyc = cyc;
        drive(p, 1'b0, op, a, b, tg);
    endtask

    task automatic get_rsp(output logic [31:0] d, output logic p, output logic [4:0] t,
                           output int c);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clock); n++;
        end
        chk("rsp_seen", rsp_valid, 1'b1);
        d = rsp_data; p = rsp_port; t = rsp_tag; c = cyc;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
    endtask

    logic [31:0] d;
    logic        p, gp, saw, stable;
    logic [4:0]  t, tg0, tg1, etag;
    logic [31:0] edat;
    int          c, g, i0, o0, n;

    initial begin
        #3 reset = 1'b0;
        req0_valid = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_mul_i_valid", mul_i_valid, 1'b0);
        chk("rst_mul_o_ready", mul_o_ready, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_multiplicand", mul_i_multiplicand, 32'd0);
        req0_valid = 1'b0;
        @(negedge clock) reset = 1'b1;
        repeat (2) @(negedge clock);

        send(0, T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        chk("mulhu_issue_next", mul_i_valid, 1'b1);
        chk("mulhu_sign", {mul_i_signed1, mul_i_signed2}, 2'b00);
        chk("mulhu_operand", mul_i_multiplicand, 32'hFFFF_FFFF);
        get_rsp(d, p, t, c);
        chk("mulhu_data", d, 32'hFFFF_FFFE);
        chk("mulhu_port", p, 1'b0);
        chk("mulhu_tag", t, 5'd5);

        send(1, T_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd12);
        chk("mulhsu_sign", {mul_i_signed1, mul_i_signed2}, 2'b10);
        get_rsp(d, p, t, c);
        chk("mulhsu_data", d, 32'hFFFF_FFFF);
        chk("mulhsu_port", p, 1'b1);
        chk("mulhsu_tag", t, 5'd12);

        send(0, T_MULH, 32'h8000_0000, 32'h8000_0000, 5'd3);
        chk("mulh_sign", {mul_i_signed1, mul_i_signed2}, 2'b11);
        get_rsp(d, p, t, c);
        chk("mulh_data", d, 32'h4000_0000);

        i0 = issue_cnt;
        send(1, T_MUL, 32'h8000_0000, 32'h8000_0000, 5'd9);
        g = gcyc;
        get_rsp(d, p, t, c);
        chk("fuse_mul_data", d, 32'h0000_0000);
        chk("fuse_mul_tag", t, 5'd9);
`ifdef LIEAT_MULCTL_FUSE_EN
        chk("fuse_no_issue", issue_cnt - i0, 0);
        chk("fuse_latency", c - g, 1);
`else
        chk("nofuse_issue", issue_cnt - i0, 1);
`endif

        // Both ports valid continuously from reset
        @(negedge clock) reset = 1'b0;
        tg0 = 5'd10; tg1 = 5'd20;
        drive(0, 1'b1, T_MUL, 32'd3, 32'd5, tg0);
        drive(1, 1'b1, T_MULHU, 32'hFFFF_FFFF, 32'd2, tg1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clock); #1;
            while (!(req0_ready || req1_ready) && n < 50) begin
                @(negedge clock); #1; n++;
            end
            gp = req1_ready;
            chk("rr_grant", gp, (k % 2 == 1) ? 1'b1 : 1'b0);
            chk("rr_onehot", req0_ready & req1_ready, 1'b0);
            etag = gp ? tg1 : tg0;
            edat = gp ? 32'd1 : 32'd15;
            @(posedge clock); #1;
            if (gp) begin tg1 = tg1 + 5'd1; req1_tag = tg1; end
            else begin tg0 = tg0 + 5'd1; req0_tag = tg0; end
            get_rsp(d, p, t, c);
            chk("rr_port", p, gp);
            chk("rr_tag", t, etag);
            chk("rr_data", d, edat);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Flush in WAIT after a completed request fills the fuse entry
        send(0, T_MUL, 32'h0000_1000, 32'h0000_2000, 5'd1);
        get_rsp(d, p, t, c);
        chk("flush_pre_data", d, 32'h0200_0000);
        send(0, T_MULHU, 32'h1234_5678, 32'h0000_0010, 5'd2);
        @(negedge clock); @(negedge clock); #1;
        chk("flush_in_wait", mul_o_ready, 1'b1);
        o0 = ores_cnt;
        flush = 1'b1;
        @(negedge clock) flush = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clock);
            saw = saw | rsp_valid;
        end
        chk("flush_no_rsp", saw, 1'b0);
        chk("flush_drained", ores_cnt - o0, 1);
        chk("flush_mul_o_idle", mul_o_valid, 1'b0);
        i0 = issue_cnt;
        send(0, T_MUL, 32'h0000_1000, 32'h0000_2000, 5'd4);
        get_rsp(d, p, t, c);
        chk("flush_repeat_miss", issue_cnt - i0, 1);
        chk("flush_repeat_data", d, 32'h0200_0000);
        send(1, T_MULHU, 32'h1234_5678, 32'h0000_0010, 5'd6);
        get_rsp(d, p, t, c);
        chk("flush_b_data", d, 32'h0000_0001);

        // Response back-pressure
        rsp_ready = 1'b0;
        send(1, T_MULHU, 32'h0000_0003, 32'h8000_0000, 5'd7);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clock); n++;
        end
        chk("stall_rsp_seen", rsp_valid, 1'b1);
        drive(0, 1'b1, T_MUL, 32'd1, 32'd1, 5'd0);
        drive(1, 1'b1, T_MUL, 32'd2, 32'd2, 5'd0);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clock); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0001 || rsp_tag !== 5'd7 ||
                rsp_port !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("stall_stable", stable, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        get_rsp(d, p, t, c);
        chk("stall_data", d, 32'h0000_0001);
        @(negedge clock); #1;
        chk("stall_done", rsp_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lieat_exu_mulctl.md
LIEAT_EXU_MULCTL -- requirements
Module: lieat_exu_mulctl

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width.
REQ-002 SHALL have parameter TAGW, default 5: request tag width.
REQ-003 SHALL have these ports, clock and reset first:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  request valid, for N=0,1.
- reqN_ready  out  1  request accepted, for N=0,1.
- reqN_op  in  2  operation, for N=0,1: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- reqN_rs1, reqN_rs2  in  XLEN  operands, for N=0,1.
- reqN_tag  in  TAGW  request tag, for N=0,1.
- flush  in  1  kill the outstanding operation.
- rsp_valid, rsp_ready  out/in  1  response handshake.
- rsp_port  out  1  index of the requester served.
- rsp_tag  out  TAGW  tag of the request served.
- rsp_data  out  XLEN  selected product half.
- mul_i_valid, mul_i_ready  out/in  1  multiplier issue handshake.
- mul_i_signed1, mul_i_signed2  out  1  operand signedness.
- mul_i_multiplicand, mul_i_multiplier  out  XLEN  multiplier operands.
- mul_o_valid, mul_o_ready  in/out  1  multiplier result handshake.
- mul_o_resh, mul_o_resl  in  XLEN  high and low product halves.

Function
REQ-004 SHALL use a one-hot FSM with states IDLE, ISSUE, WAIT, RESP and DRAIN.
REQ-005 In IDLE with flush low, SHALL grant one valid requester: reqN_ready=1 only for the granted N.
- Both valid: grant the round-robin pointer's port.
- After any grant, the pointer moves to the other port.
REQ-006 On grant, SHALL register port, tag, op, rs1 and rs2, then go to ISSUE (miss) or RESP (fuse hit, REQ-013).
REQ-007 SHALL decode signedness (signed1, signed2) as:
- MUL, MULH: 1,1.
- MULHSU: 1,0.
- MULHU: 0,0.
REQ-008 In ISSUE, SHALL assert mul_i_valid with the registered operands, held stable; on mul_i_valid&mul_i_ready go to WAIT.
REQ-009 In WAIT, SHALL assert mul_o_ready; on mul_o_valid, capture {resh,resl} and go to RESP.
REQ-010 SHALL select rsp_data as mul_o_resl for MUL and mul_o_resh otherwise.
REQ-011 In RESP, SHALL assert rsp_valid with port, tag and data held stable until rsp_ready; on the handshake go to IDLE.
REQ-012 Flush SHALL have priority over every same-cycle handshake:
- IDLE: no grant.
- ISSUE: go to IDLE; mul_i_valid drops next cycle.
- WAIT: go to DRAIN.
- RESP: drop the response and go to IDLE.
- DRAIN: keep mul_o_ready=1; on mul_o_valid, discard the result and go to IDLE; no rsp_valid.
REQ-013 (fuse) SHALL hold a last-result entry {valid, rs1, rs2, signed1, signed2, 64-bit product}, written on every WAIT capture.
- Hit when valid, rs1 and rs2 equal, and (op=MUL or signedness equal).
- A hit skips the multiplier; rsp_valid asserts the cycle after grant.
- Flush in any state clears the entry's valid bit.
REQ-014 Miss latency: mul_i_valid asserts the cycle after grant. Hit latency: 1 cycle.

Reset
REQ-015 On reset assertion, SHALL asynchronously force:
- FSM to IDLE and pointer to port 0.
- Fuse entry invalid.
- All valid/ready outputs 0 and data outputs 0.
REQ-016 Reset mid-operation SHALL abandon it silently; the multiplier is reset by the same reset.

Configuration
REQ-017 LIEAT_MULCTL_FUSE_EN defined SHALL compile in REQ-013. Undefined, the fuse storage SHALL be absent and every request SHALL take the ISSUE path.

Structure
REQ-018 SHALL place op encodings and the FSM state/bit-index constants in a shared defines header.
REQ-019 SHALL implement arbitration as sub-module lieat_general_rrarb2: two requests, pointer, one-hot grant, advance enable.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- req0 MULHU 0xFFFFFFFF×0xFFFFFFFF -> rsp_data 0xFFFFFFFE, rsp_port 0, tag echoed.
- req1 MULHSU 0xFFFFFFFF×0x00000002 -> rsp_data 0xFFFFFFFF; MULH 0x80000000×0x80000000 -> 0x40000000.
- Fuse on: MULH, then MUL of 0x80000000×0x80000000 -> second rsp_data 0x00000000 one cycle after grant, no mul_i_valid. Fuse off: second request issues.
- Both ports valid continuously from reset -> grants 0,1,0,1; tags returned in grant order.
- Flush in WAIT -> no rsp_valid, result drained; an identical repeat request misses.
- rsp_ready low 10 cycles -> rsp_* stable, both reqN_ready 0 throughout.
